// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable modulus, variable step,
// parallel load, and wrap or saturate overflow handling with ovf/unf pulses.
module updown_counter_mod #(
    parameter int                WIDTH    = 4,
    parameter longint unsigned   MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit                SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_down,
    input  logic             count_load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             is_max,
    output logic             is_zero
);

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + 1'b1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   s_eff;
    logic [WIDTH:0]   sum_up;
    logic             up_cross;
    logic             dn_cross;

    // One extra bit of headroom keeps count+s and count+modulus exact.
    always_comb begin
        cnt_ext  = {1'b0, count_q};
        step_ext = {1'b0, step};
        s_eff    = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
        sum_up   = cnt_ext + s_eff;
        up_cross = (sum_up > MAX_EXT);
        dn_cross = (s_eff > cnt_ext);
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (count_load) begin
            count_d = (load_value > MAX_W) ? MAX_W : load_value;
        end else if (enable && (s_eff != '0)) begin
            if (up_down) begin
                if (!up_cross) begin
                    count_d = WIDTH'(sum_up);
                end else begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? MAX_W : WIDTH'(sum_up - MOD_EXT);
                end
            end else begin
                if (!dn_cross) begin
                    count_d = WIDTH'(cnt_ext - s_eff);
                end else begin
                    unf_d   = 1'b1;
                    count_d = SATURATE ? '0 : WIDTH'(cnt_ext + MOD_EXT - s_eff);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign is_max  = (count_q == MAX_W);
    assign is_zero = (count_q == '0);

endmodule
